// File: rtl/rect_raster_engine_pkg.sv
// ============================================================================
// Module   : draw_pkg
// Brief    : Shared drawing-path types: draw modes, raster FSM states, screen
//            and colour defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package draw_pkg;

    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_ERASE   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] COLOUR_BLACK = 3'd0;

    function automatic logic is_outline(input logic [1:0] m);
        return m == MODE_OUTLINE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rect_raster_engine_if.sv
// ============================================================================
// Module   : rect_raster_engine_if
// Brief    : Rectangle request bundle and pixel plot bundle of the rasteriser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rect_raster_engine_if #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int SIZE_W = 5,
    parameter int C_W    = 3
);
    logic              start;
    logic [X_W-1:0]    x_in;
    logic [Y_W-1:0]    y_in;
    logic [SIZE_W-1:0] width;
    logic [SIZE_W-1:0] height;
    logic [C_W-1:0]    colour;
    logic [C_W-1:0]    bg_colour;
    logic [1:0]        mode;
    logic              busy;
    logic              plot;
    logic [X_W-1:0]    x_out;
    logic [Y_W-1:0]    y_out;
    logic [C_W-1:0]    c_out;
    logic              done;

    modport master (
        output start, x_in, y_in, width, height, colour, bg_colour, mode,
        input  busy, plot, x_out, y_out, c_out, done
    );

    modport slave (
        input  start, x_in, y_in, width, height, colour, bg_colour, mode,
        output busy, plot, x_out, y_out, c_out, done
    );
endinterface

`default_nettype wire

// File: rtl/rect_raster_engine_counter.sv
// ============================================================================
// Module   : raster_counter
// Brief    : Row-major col/row scan counter; exposes next-position values so
//            the caller can register pixel outputs in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_counter #(
    parameter int W = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clear,
    input  wire logic         advance,
    input  wire logic [W-1:0] col_lim,
    input  wire logic [W-1:0] row_lim,
    output logic      [W-1:0] col_nxt,
    output logic      [W-1:0] row_nxt,
    output logic              last
);
    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_col;
    logic [W-1:0] r_row;
    logic         w_col_end;

    assign w_col_end = (r_col == col_lim);
    assign last      = w_col_end && (r_row == row_lim);

    always_comb begin
        col_nxt = r_col;
        row_nxt = r_row;
        if (clear) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (advance) begin
            if (w_col_end) begin
                col_nxt = '0;
                row_nxt = r_row + C_ONE;
            end else begin
                col_nxt = r_col + C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= col_nxt;
            r_row <= row_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rect_raster_engine.sv
// ============================================================================
// Module   : rect_raster_engine
// Brief    : Rectangle rasteriser (fill/outline/erase, clipped) emitting one
//            registered pixel per clock to the VGA plot interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_raster_engine
    import draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SIZE_W   = 5,
    parameter int C_W      = 3,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input wire logic             clk,
    input wire logic             reset,
    rect_raster_engine_if.slave  bus
);
    localparam logic [SIZE_W-1:0] C_ONE   = {{(SIZE_W-1){1'b0}}, 1'b1};
    localparam logic [X_W:0]      C_X_LIM = SCREEN_W[X_W:0];
    localparam logic [Y_W:0]      C_Y_LIM = SCREEN_H[Y_W:0];

    state_t            r_state, w_state_nxt;
    logic [X_W-1:0]    r_x0, w_x0_n;
    logic [Y_W-1:0]    r_y0, w_y0_n;
    logic [SIZE_W-1:0] r_w, w_w_n;
    logic [SIZE_W-1:0] r_h, w_h_n;
    logic [1:0]        r_mode, w_mode_n;
    logic [C_W-1:0]    r_colour, w_colour_n;

    logic [SIZE_W-1:0] w_col_n, w_row_n;
    logic              w_last;
    logic [X_W:0]      w_x_sum;
    logic [Y_W:0]      w_y_sum;
    logic              w_in_shape;
    logic              w_plot_n;

    logic              r_plot, r_done, r_busy;
    logic [X_W-1:0]    r_x_out;
    logic [Y_W-1:0]    r_y_out;
    logic [C_W-1:0]    r_c_out;

    raster_counter #(.W(SIZE_W)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state != ST_DRAW),
        .advance (r_state == ST_DRAW),
        .col_lim (r_w - C_ONE),
        .row_lim (r_h - C_ONE),
        .col_nxt (w_col_n),
        .row_nxt (w_row_n),
        .last    (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_x0_n      = r_x0;
        w_y0_n      = r_y0;
        w_w_n       = r_w;
        w_h_n       = r_h;
        w_mode_n    = r_mode;
        w_colour_n  = r_colour;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_x0_n      = bus.x_in;
                    w_y0_n      = bus.y_in;
                    w_w_n       = bus.width;
                    w_h_n       = bus.height;
                    w_mode_n    = bus.mode;
                    w_colour_n  = (bus.mode == MODE_ERASE) ? bus.bg_colour : bus.colour;
                    w_state_nxt = (bus.width == '0 || bus.height == '0) ? ST_DONE : ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pixel outputs are computed from the position entered on this edge so
    // that they are registered yet valid in the first scan cycle.
    assign w_x_sum    = {1'b0, w_x0_n} + {{(X_W+1-SIZE_W){1'b0}}, w_col_n};
    assign w_y_sum    = {1'b0, w_y0_n} + {{(Y_W+1-SIZE_W){1'b0}}, w_row_n};
    assign w_in_shape = !is_outline(w_mode_n)
                        || (w_col_n == '0) || (w_col_n == w_w_n - C_ONE)
                        || (w_row_n == '0) || (w_row_n == w_h_n - C_ONE);
    assign w_plot_n   = (w_state_nxt == ST_DRAW) && w_in_shape
                        && (w_x_sum < C_X_LIM) && (w_y_sum < C_Y_LIM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_mode   <= MODE_FILL;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_x_out  <= '0;
            r_y_out  <= '0;
            r_c_out  <= C_W'(COLOUR_BLACK);
        end else begin
            r_state  <= w_state_nxt;
            r_x0     <= w_x0_n;
            r_y0     <= w_y0_n;
            r_w      <= w_w_n;
            r_h      <= w_h_n;
            r_mode   <= w_mode_n;
            r_colour <= w_colour_n;
            r_plot   <= w_plot_n;
            r_done   <= (w_state_nxt == ST_DONE);
            r_busy   <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_DRAW) begin
                r_x_out <= w_x_sum[X_W-1:0];
                r_y_out <= w_y_sum[Y_W-1:0];
                r_c_out <= w_colour_n;
            end
        end
    end

    assign bus.plot  = r_plot;
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;
    assign bus.x_out = r_x_out;
    assign bus.y_out = r_y_out;
    assign bus.c_out = r_c_out;

endmodule

`default_nettype wire

// File: tb/tb_rect_raster_engine.sv
// ============================================================================
// Module   : tb_rect_raster_engine
// Brief    : Directed, table-driven self-checking bench for rect_raster_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rect_raster_engine;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [4:0] w;
        logic [4:0] h;
        logic [2:0] c;
        logic [2:0] bg;
        logic [1:0] m;
        int         e_np;
        int         e_lat;
        int         e_sx;
        int         e_sy;
        logic [2:0] e_c;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rect_raster_engine_if #(.X_W(8), .Y_W(7), .SIZE_W(5), .C_W(3)) bus ();

    rect_raster_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        @(negedge clk);
        bus.x_in      = v.x;
        bus.y_in      = v.y;
        bus.width     = v.w;
        bus.height    = v.h;
        bus.colour    = v.c;
        bus.bg_colour = v.bg;
        bus.mode      = v.m;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.x_in      = 8'($urandom);
        bus.y_in      = 7'($urandom);
        bus.width     = 5'($urandom);
        bus.height    = 5'($urandom);
        bus.colour    = 3'($urandom);
        bus.bg_colour = 3'($urandom);
        bus.mode      = 2'($urandom);
    endtask

    // Leaves the caller in the cycle where done was seen (or after timeout).
    task automatic run_rect(input vec_t v, output int np, output int sx,
                            output int sy, output int bad, output int lat);
        np = 0; sx = 0; sy = 0; bad = 0; lat = -1;
        drive_req(v);
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.plot) begin
                np++;
                sx += int'(bus.x_out);
                sy += int'(bus.y_out);
                if (bus.c_out !== v.e_c) bad++;
            end
            if (bus.busy !== 1'b1) bad++;
        end
    endtask

    vec_t       vecs[9];
    vec_t       v;
    int         np, sx, sy, bad, lat, dones;
    logic [19:0] exp_seq[4];
    logic [8:0]  scan_plots;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.width = '0;
        bus.height = '0; bus.colour = '0; bus.bg_colour = '0; bus.mode = '0;

        //            x    y   w   h   c  bg  mode   np lat  sumx  sumy  col
        vecs[0] = '{8'd10, 7'd20, 5'd2, 5'd2, 3'd5, 3'd1, 2'b00, 4, 5, 42, 82, 3'd5};
        vecs[1] = '{8'd0, 7'd0, 5'd3, 5'd3, 3'd3, 3'd1, 2'b01, 8, 10, 8, 8, 3'd3};
        vecs[2] = '{8'd158, 7'd118, 5'd4, 5'd4, 3'd2, 3'd1, 2'b00, 4, 17, 634, 474, 3'd2};
        vecs[3] = '{8'd30, 7'd30, 5'd0, 5'd7, 3'd2, 3'd1, 2'b00, 0, 1, 0, 0, 3'd2};
        vecs[4] = '{8'd5, 7'd5, 5'd1, 5'd3, 3'd6, 3'd0, 2'b10, 3, 4, 15, 18, 3'd0};
        vecs[5] = '{8'd150, 7'd10, 5'd3, 5'd1, 3'd1, 3'd4, 2'b10, 3, 4, 453, 30, 3'd4};
        vecs[6] = '{8'd20, 7'd30, 5'd2, 5'd1, 3'd7, 3'd1, 2'b11, 2, 3, 41, 60, 3'd7};
        vecs[7] = '{8'd50, 7'd60, 5'd1, 5'd4, 3'd1, 3'd2, 2'b01, 4, 5, 200, 246, 3'd1};
        vecs[8] = '{8'd100, 7'd100, 5'd4, 5'd3, 3'd4, 3'd2, 2'b01, 10, 13, 1015, 1010, 3'd4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {bus.plot, bus.done, bus.busy, bus.x_out, bus.y_out, bus.c_out}, 0);
        reset = 1'b1;

        // Cycle-exact fill 2x2 at (10,20), colour 5.
        exp_seq[0] = {1'b0, 1'b1, 8'd10, 7'd20, 3'd5};
        exp_seq[1] = {1'b0, 1'b1, 8'd11, 7'd20, 3'd5};
        exp_seq[2] = {1'b0, 1'b1, 8'd10, 7'd21, 3'd5};
        exp_seq[3] = {1'b0, 1'b1, 8'd11, 7'd21, 3'd5};
        drive_req(vecs[0]);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            chk($sformatf("fill2x2_cyc%0d", c),
                {bus.done, bus.plot, bus.x_out, bus.y_out, bus.c_out}, exp_seq[c-1]);
        end
        @(negedge clk);
        chk("fill2x2_done", {bus.done, bus.plot, bus.busy}, 3'b101);
        @(negedge clk);
        chk("fill2x2_busy_fall", {bus.done, bus.busy}, 2'b00);

        // Outline 3x3: interior (1,1) is scan position 4.
        drive_req(vecs[1]);
        scan_plots = '0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            scan_plots[c-1] = bus.plot;
        end
        chk("outline3x3_plot_map", scan_plots, 9'b111101111);
        @(negedge clk);
        chk("outline3x3_done_t10", bus.done, 1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            run_rect(v, np, sx, sy, bad, lat);
            chk($sformatf("vec%0d_plots", i), np, v.e_np);
            chk($sformatf("vec%0d_done_cycle", i), lat, v.e_lat);
            chk($sformatf("vec%0d_sum_x", i), sx, v.e_sx);
            chk($sformatf("vec%0d_sum_y", i), sy, v.e_sy);
            chk($sformatf("vec%0d_colour_busy_errs", i), bad, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_idle_after_done", i), {bus.busy, bus.done}, 0);
        end

        // Start while busy is ignored; reset mid-draw aborts with no done.
        v = '{8'd0, 7'd0, 5'd4, 5'd4, 3'd1, 3'd0, 2'b00, 16, 17, 0, 0, 3'd1};
        drive_req(v);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 3) begin
                bus.start = 1'b1; bus.x_in = 8'd100; bus.y_in = 7'd50;
                bus.width = 5'd1; bus.height = 5'd1; bus.mode = 2'b00;
            end
            if (c == 4) begin
                bus.start = 1'b0;
                chk("busy_start_ignored", {bus.plot, bus.x_out, bus.y_out}, {1'b1, 8'd3, 7'd0});
            end
            if (c == 6) begin
                chk("busy_cyc6_pixel", {bus.plot, bus.x_out, bus.y_out}, {1'b1, 8'd1, 7'd1});
                reset = 1'b0;
            end
        end
        @(negedge clk);
        chk("reset_abort_outputs", {bus.plot, bus.busy, bus.done}, 3'b000);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("reset_abort_no_done", dones, 0);

        v = vecs[0];
        run_rect(v, np, sx, sy, bad, lat);
        chk("after_reset_plots", np, 4);
        chk("after_reset_done_cycle", lat, 5);
        chk("after_reset_sums", sx * 1000 + sy, 42082);
        chk("after_reset_colour_busy_errs", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
